// File: rtl/dport_axi_pkg.sv
// rtl/dport_axi_pkg.sv - shared FSM encodings and AXI response codes for dport_axi_slave
package dport_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Map the memory-side error flag onto an AXI response code
    function automatic logic [1:0] ack_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/dport_axi_slave_hold.sv
// rtl/dport_axi_slave_hold.sv - one-entry holding register for an AXI request channel
module dport_axi_slave_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_clear,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // Capture when empty; clear takes priority (ready is low while full, so no overlap)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/dport_axi_slave.sv
// rtl/dport_axi_slave.sv - AXI4-Lite responder driving a single-outstanding core memory port
module dport_axi_slave
    import dport_axi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit READ_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axi_awvalid_i,
    input  logic [ADDR_W-1:0] axi_awaddr_i,
    output logic              axi_awready_o,
    input  logic              axi_wvalid_i,
    input  logic [31:0]       axi_wdata_i,
    input  logic [3:0]        axi_wstrb_i,
    output logic              axi_wready_o,
    output logic              axi_bvalid_o,
    output logic [1:0]        axi_bresp_o,
    input  logic              axi_bready_i,
    input  logic              axi_arvalid_i,
    input  logic [ADDR_W-1:0] axi_araddr_i,
    output logic              axi_arready_o,
    output logic              axi_rvalid_o,
    output logic [31:0]       axi_rdata_o,
    output logic [1:0]        axi_rresp_o,
    input  logic              axi_rready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_wr_o,
    output logic              mem_rd_o,
    output logic [3:0]        mem_wr_o,
    input  logic              mem_accept_i,
    input  logic              mem_ack_i,
    input  logic              mem_error_i,
    input  logic [31:0]       mem_data_rd_i
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

    state_t            r_state;
    logic              r_alive;
    logic              r_is_rd;
    logic              r_last_rd;
    logic              r_mem_rd;
    logic [3:0]        r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic [31:0]       r_rdata;

    logic              w_aw_full, w_w_full, w_ar_full;
    logic [ADDR_W-1:0] w_aw_addr, w_ar_addr;
    logic [35:0]       w_w_data;
    logic              w_wr_rdy, w_rd_rdy, w_pick_rd, w_in_idle;
    logic              w_clr_ar, w_clr_wr, w_ack_take;

    // Readies stay low until the first edge after reset so every ready output reads 0 in reset
    dport_axi_slave_hold #(.W(ADDR_W)) u_aw_hold (
        .clk(clk), .rst(rst), .i_valid(axi_awvalid_i & r_alive), .i_data(axi_awaddr_i),
        .i_clear(w_clr_wr), .o_full(w_aw_full), .o_data(w_aw_addr)
    );
    dport_axi_slave_hold #(.W(36)) u_w_hold (
        .clk(clk), .rst(rst), .i_valid(axi_wvalid_i & r_alive), .i_data({axi_wstrb_i, axi_wdata_i}),
        .i_clear(w_clr_wr), .o_full(w_w_full), .o_data(w_w_data)
    );
    dport_axi_slave_hold #(.W(ADDR_W)) u_ar_hold (
        .clk(clk), .rst(rst), .i_valid(axi_arvalid_i & r_alive), .i_data(axi_araddr_i),
        .i_clear(w_clr_ar), .o_full(w_ar_full), .o_data(w_ar_addr)
    );

    assign w_wr_rdy   = w_aw_full & w_w_full;
    assign w_rd_rdy   = w_ar_full;
    // The last-grant flag only moves on contested cycles, so back-to-back contests alternate
    assign w_pick_rd  = w_rd_rdy & (~w_wr_rdy | ~r_last_rd);
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_clr_ar   = w_in_idle & w_pick_rd;
    assign w_clr_wr   = w_in_idle & ~w_pick_rd & w_wr_rdy;
    assign w_ack_take = mem_ack_i & (((r_state == ST_REQ) & mem_accept_i) | (r_state == ST_WAIT));

    // Transaction FSM: dispatch, memory request/response, AXI response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_alive    <= 1'b0;
            r_is_rd    <= 1'b0;
            r_last_rd  <= ~READ_FIRST;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 4'd0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_clr_ar) begin
                        if (w_wr_rdy) r_last_rd <= 1'b1;
                        r_is_rd    <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_ar_addr & ADDR_MASK;
                        r_mem_data <= '0;
                        r_state    <= ST_REQ;
                    end else if (w_clr_wr) begin
                        if (w_rd_rdy) r_last_rd <= 1'b0;
                        r_is_rd <= 1'b0;
                        if (w_w_data[35:32] == 4'd0) begin
                            // Nothing to write: answer immediately without touching memory
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_OKAY;
                            r_state  <= ST_RESP;
                        end else begin
                            r_mem_wr   <= w_w_data[35:32];
                            r_mem_addr <= w_aw_addr & ADDR_MASK;
                            r_mem_data <= w_w_data[31:0];
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_accept_i) begin
                        r_mem_rd   <= 1'b0;
                        r_mem_wr   <= 4'd0;
                        r_mem_addr <= '0;
                        r_mem_data <= '0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: ;
                ST_RESP: begin
                    if ((r_bvalid && axi_bready_i) || (r_rvalid && axi_rready_i)) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_ack_take) begin
                if (r_is_rd) begin
                    r_rvalid <= 1'b1;
                    r_rresp  <= ack_resp(mem_error_i);
                    r_rdata  <= mem_data_rd_i;
                end else begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= ack_resp(mem_error_i);
                end
                r_state <= ST_RESP;
            end
        end
    end

    assign axi_awready_o = r_alive & ~w_aw_full;
    assign axi_wready_o  = r_alive & ~w_w_full;
    assign axi_arready_o = r_alive & ~w_ar_full;
    assign axi_bvalid_o  = r_bvalid;
    assign axi_bresp_o   = r_bresp;
    assign axi_rvalid_o  = r_rvalid;
    assign axi_rresp_o   = r_rresp;
    assign axi_rdata_o   = r_rdata;
    assign mem_addr_o    = r_mem_addr;
    assign mem_data_wr_o = r_mem_data;
    assign mem_rd_o      = r_mem_rd;
    assign mem_wr_o      = r_mem_wr;

endmodule

// File: tb/tb_dport_axi_slave.sv
// tb/tb_dport_axi_slave.sv - directed scoreboard bench for dport_axi_slave
module tb_dport_axi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axi_awvalid_i = 0, axi_wvalid_i = 0, axi_arvalid_i = 0;
    logic [31:0] axi_awaddr_i = 0, axi_araddr_i = 0, axi_wdata_i = 0;
    logic [3:0]  axi_wstrb_i = 0;
    logic        axi_bready_i = 0, axi_rready_i = 0;
    logic        axi_awready_o, axi_wready_o, axi_arready_o, axi_bvalid_o, axi_rvalid_o;
    logic [1:0]  axi_bresp_o, axi_rresp_o;
    logic [31:0] axi_rdata_o, mem_addr_o, mem_data_wr_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic        mem_accept_i = 0, mem_ack_i = 0, mem_error_i = 0;
    logic [31:0] mem_data_rd_i = 0;

    typedef struct {
        logic        is_rd;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    dport_axi_slave #(.ADDR_W(32), .READ_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .axi_awvalid_i(axi_awvalid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awready_o(axi_awready_o),
        .axi_wvalid_i(axi_wvalid_i), .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
        .axi_wready_o(axi_wready_o),
        .axi_bvalid_o(axi_bvalid_o), .axi_bresp_o(axi_bresp_o), .axi_bready_i(axi_bready_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_araddr_i(axi_araddr_i), .axi_arready_o(axi_arready_o),
        .axi_rvalid_o(axi_rvalid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rready_i(axi_rready_i),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
        .mem_error_i(mem_error_i), .mem_data_rd_i(mem_data_rd_i)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic rd, input logic [31:0] a, input logic [3:0] s,
                                input logic [31:0] wd, input logic [1:0] r, input logic [31:0] rdd);
        exp_t e;
        e.is_rd = rd; e.addr = a; e.strb = s; e.wdata = wd; e.resp = r; e.rdata = rdd;
        return e;
    endfunction

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        axi_awvalid_i = 1; axi_awaddr_i = a;
        while (axi_awready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("aw_timeout", 64'(n < 50), 64'd1);
        @(negedge clk); axi_awvalid_i = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        axi_wvalid_i = 1; axi_wdata_i = d; axi_wstrb_i = s;
        while (axi_wready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("w_timeout", 64'(n < 50), 64'd1);
        @(negedge clk); axi_wvalid_i = 0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        axi_arvalid_i = 1; axi_araddr_i = a;
        while (axi_arready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("ar_timeout", 64'(n < 50), 64'd1);
        @(negedge clk); axi_arvalid_i = 0;
    endtask

    // Memory model: checks the request against the scoreboard head and answers from it
    task automatic serve(input int acc_dly, input int ack_dly);
        exp_t e;
        logic [36:0] req_exp;
        int n = 0;
        while (mem_rd_o === 1'b0 && mem_wr_o === 4'd0 && n < 50) begin @(negedge clk); n++; end
        chk("mem_req_timeout", 64'(n < 50), 64'd1);
        e = sb[0];
        req_exp = {e.is_rd, (e.is_rd ? 4'd0 : e.strb), e.addr & 32'hFFFF_FFFC};
        chk("mem_req", {mem_rd_o, mem_wr_o, mem_addr_o}, req_exp);
        if (!e.is_rd) chk("mem_wdata", mem_data_wr_o, e.wdata);
        repeat (acc_dly) begin
            @(negedge clk);
            chk("mem_req_hold", {mem_rd_o, mem_wr_o, mem_addr_o}, req_exp);
        end
        mem_accept_i = 1; mem_ack_i = (ack_dly == 0);
        mem_error_i = (e.resp == 2'b10); mem_data_rd_i = e.rdata;
        @(negedge clk);
        mem_accept_i = 0; mem_ack_i = 0;
        if (ack_dly > 0) begin
            repeat (ack_dly - 1) begin
                chk("mem_wait_idle", {mem_rd_o, mem_wr_o}, 0);
                @(negedge clk);
            end
            chk("mem_wait_idle", {mem_rd_o, mem_wr_o}, 0);
            mem_ack_i = 1;
            @(negedge clk);
            mem_ack_i = 0;
        end
        mem_error_i = 0;
    endtask

    // Response checker: pops the scoreboard head when B or R valid appears
    task automatic get_resp(input int rdy_dly);
        exp_t e;
        logic [34:0] obs, expv;
        int n = 0;
        while (axi_bvalid_o !== 1'b1 && axi_rvalid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("resp_timeout", 64'(n < 50), 64'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        expv = {1'b1, e.resp, (e.is_rd ? e.rdata : 32'd0)};
        chk("resp_channel", {axi_bvalid_o, axi_rvalid_o}, {~e.is_rd, e.is_rd});
        obs = e.is_rd ? {axi_rvalid_o, axi_rresp_o, axi_rdata_o} : {axi_bvalid_o, axi_bresp_o, 32'd0};
        chk("resp_value", obs, expv);
        repeat (rdy_dly) begin
            @(negedge clk);
            obs = e.is_rd ? {axi_rvalid_o, axi_rresp_o, axi_rdata_o} : {axi_bvalid_o, axi_bresp_o, 32'd0};
            chk("resp_hold", obs, expv);
        end
        axi_bready_i = ~e.is_rd; axi_rready_i = e.is_rd;
        @(negedge clk);
        axi_bready_i = 0; axi_rready_i = 0;
        chk("resp_drop", {axi_bvalid_o, axi_rvalid_o}, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {axi_awready_o, axi_wready_o, axi_arready_o, axi_bvalid_o, axi_rvalid_o,
                  mem_rd_o, mem_wr_o, axi_bresp_o, axi_rresp_o}, 0);
        chk({tag, "_data"}, {axi_rdata_o, mem_addr_o}, 0);
        chk({tag, "_wdata"}, mem_data_wr_o, 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        rst = 0;
        @(negedge clk); @(negedge clk);
        chk("ready_after_reset", {axi_awready_o, axi_wready_o, axi_arready_o}, 3'b111);

        // Simultaneous arbitration, round 1: read wins after reset
        sb.push_back(mk(1, 32'h100, 4'h0, 0, 2'b00, 32'hA5A5_0001));
        sb.push_back(mk(0, 32'h200, 4'hF, 32'h1111_2222, 2'b00, 0));
        axi_arvalid_i = 1; axi_araddr_i = 32'h100;
        axi_awvalid_i = 1; axi_awaddr_i = 32'h200;
        axi_wvalid_i = 1; axi_wdata_i = 32'h1111_2222; axi_wstrb_i = 4'hF;
        @(negedge clk);
        axi_arvalid_i = 0; axi_awvalid_i = 0; axi_wvalid_i = 0;
        chk("arb1_queued", {axi_awready_o, axi_wready_o, axi_arready_o}, 3'b000);
        @(negedge clk);
        chk("arb1_first", {mem_rd_o, mem_wr_o, axi_awready_o, axi_wready_o, axi_arready_o}, 8'b1_0000_001);
        serve(0, 0); get_resp(0); serve(0, 0); get_resp(0);

        // Round 2: write wins
        sb.push_back(mk(0, 32'h300, 4'hF, 32'h3333_4444, 2'b00, 0));
        sb.push_back(mk(1, 32'h400, 4'h0, 0, 2'b00, 32'hA5A5_0002));
        axi_arvalid_i = 1; axi_araddr_i = 32'h400;
        axi_awvalid_i = 1; axi_awaddr_i = 32'h300;
        axi_wvalid_i = 1; axi_wdata_i = 32'h3333_4444; axi_wstrb_i = 4'hF;
        @(negedge clk);
        axi_arvalid_i = 0; axi_awvalid_i = 0; axi_wvalid_i = 0;
        @(negedge clk);
        chk("arb2_first", {mem_rd_o, mem_wr_o, axi_awready_o, axi_wready_o, axi_arready_o}, 8'b0_1111_110);
        serve(0, 0); get_resp(0); serve(0, 0); get_resp(0);

        // Single write: request one cycle after handshake, bvalid two cycles after
        sb.push_back(mk(0, 32'h0000_1006, 4'b1100, 32'hDEAD_BEEF, 2'b00, 0));
        axi_awvalid_i = 1; axi_awaddr_i = 32'h0000_1006;
        axi_wvalid_i = 1; axi_wdata_i = 32'hDEAD_BEEF; axi_wstrb_i = 4'b1100;
        mem_accept_i = 1; mem_ack_i = 1;
        @(negedge clk);
        axi_awvalid_i = 0; axi_wvalid_i = 0;
        chk("sw_no_req_yet", {mem_rd_o, mem_wr_o, axi_bvalid_o}, 0);
        @(negedge clk);
        chk("sw_req", {mem_wr_o, mem_addr_o, mem_data_wr_o}, {4'b1100, 32'h0000_1004, 32'hDEAD_BEEF});
        @(negedge clk);
        mem_accept_i = 0; mem_ack_i = 0;
        chk("sw_latency", {axi_bvalid_o, axi_bresp_o, mem_wr_o}, {1'b1, 2'b00, 4'd0});
        get_resp(0);

        // Decoupled write: W first, slow accept, delayed ack, delayed bready
        sb.push_back(mk(0, 32'h0000_2000, 4'b0011, 32'hCAFE_F00D, 2'b00, 0));
        send_w(32'hCAFE_F00D, 4'b0011);
        repeat (3) @(negedge clk);
        chk("dw_w_waiting", {axi_wready_o, axi_awready_o, mem_wr_o}, 6'b01_0000);
        send_aw(32'h0000_2000);
        serve(4, 2); get_resp(5);

        // Read error
        sb.push_back(mk(1, 32'h20, 4'h0, 0, 2'b10, 32'h1234_5678));
        send_ar(32'h20);
        serve(1, 1); get_resp(2);

        // Zero-strobe write, then a stray ack in IDLE
        sb.push_back(mk(0, 32'h80, 4'h0, 32'h5555_AAAA, 2'b00, 0));
        axi_awvalid_i = 1; axi_awaddr_i = 32'h80;
        axi_wvalid_i = 1; axi_wdata_i = 32'h5555_AAAA; axi_wstrb_i = 4'h0;
        @(negedge clk);
        axi_awvalid_i = 0; axi_wvalid_i = 0;
        repeat (3) begin
            @(negedge clk);
            chk("zs_no_mem_req", {mem_rd_o, mem_wr_o}, 0);
        end
        get_resp(1);
        mem_ack_i = 1; mem_error_i = 1; mem_data_rd_i = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack_i = 0; mem_error_i = 0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack", {axi_bvalid_o, axi_rvalid_o, mem_rd_o, mem_wr_o}, 0);
        end

        // Reset while waiting for ack
        sb.push_back(mk(1, 32'h40, 4'h0, 0, 2'b00, 32'h0F0F_0F0F));
        send_ar(32'h40);
        begin
            int n = 0;
            while (mem_rd_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chk("rst_req_timeout", 64'(n < 50), 64'd1);
        end
        mem_accept_i = 1;
        @(negedge clk);
        mem_accept_i = 0;
        chk("rst_in_wait", {mem_rd_o, axi_rvalid_o}, 0);
        rst = 1;
        #1;
        chk_all_zero("rst_mid");
        sb.delete();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        mem_ack_i = 1; mem_data_rd_i = 32'hDEAD_0000;
        @(negedge clk);
        mem_ack_i = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_late_ack", {axi_bvalid_o, axi_rvalid_o, axi_rdata_o}, 0);
        end
        sb.push_back(mk(1, 32'h44, 4'h0, 0, 2'b00, 32'h7777_8888));
        send_ar(32'h44);
        serve(0, 0); get_resp(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
